// File: rtl/tx_byte_fifo_if.sv
// ---------------------------------------------------------------------------
// tx_byte_fifo_if
//   Simple word handshake between the tx datapath blocks.
//
//   Handshake: the master drives data and raises rdy while data is valid.
//   The slave answers with a one-cycle ack pulse in the cycle after it
//   takes the word. The master may change data and rdy during that ack
//   cycle (the slave ignores rdy while ack is high), so a new word can be
//   offered every second cycle at most.
//
//   Signals:
//     data  master->slave  DATA_WIDTH  word
//     rdy   master->slave  1           data valid
//     ack   slave->master  1           one-cycle pulse: word taken
// ---------------------------------------------------------------------------
interface tx_byte_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  rdy;
    logic                  ack;

    modport master (
        output data,
        output rdy,
        input  ack
    );

    modport slave (
        input  data,
        input  rdy,
        output ack
    );
endinterface

// File: rtl/tx_byte_fifo.sv
// ---------------------------------------------------------------------------
// tx_byte_fifo
//   Elastic byte buffer between tx_protocol and the FT245 transmit input.
//   Absorbs bursts while the FT245 stalls; reports fill level and an
//   almost-full flag for rate monitoring.
//
//   Ports:
//     clk            in   system clock (100 MHz PLL)
//     rst            in   synchronous active-high reset, clears everything
//     flush          in   one-cycle discard of all contents (out_data held)
//     in_if          slave  upstream words (data/rdy in, ack out)
//     out_if         master words to the FT245 side (data/rdy out, ack in)
//     level          out  words held, including the one on out_if.data
//     almost_full    out  level >= AFULL_THRESHOLD
//     out_state_dbg  out  output FSM state (1 = PRESENT)
// ---------------------------------------------------------------------------
module tx_byte_fifo #(
    parameter int DATA_WIDTH      = 8,
    parameter int DEPTH_LOG2      = 9,
    parameter int AFULL_THRESHOLD = 448
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    tx_byte_fifo_if.slave         in_if,
    tx_byte_fifo_if.master        out_if,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  almost_full,
    output logic                  out_state_dbg
);
    localparam int                  DEPTH   = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_L = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] AFULL_L = (DEPTH_LOG2 + 1)'(AFULL_THRESHOLD);
    localparam logic [DEPTH_LOG2:0] ONE     = (DEPTH_LOG2 + 1)'(1);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } out_state_t;

    out_state_t state_q, state_d;

    // Pointers carry one extra bit so full and empty RAM are distinguishable.
    logic [DEPTH_LOG2:0]   wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   level_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_en;
    logic                  rd_en;
    logic                  consume;

    // in_if.rdy is ignored during the ack cycle so each word is taken once.
    // level (not RAM occupancy) gates writes: the presented word still
    // holds its slot until it is acked.
    assign wr_en = in_if.rdy && !in_if.ack && (level < DEPTH_L) && !flush;

    // Output FSM: next state and read/consume strobes.
    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        consume = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_ptr != rd_ptr) begin
                    state_d = PRESENT;
                    rd_en   = 1'b1;
                end
            end
            PRESENT: begin
                if (out_if.ack) begin
                    state_d = IDLE;
                    consume = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        level_d = level;
        if (wr_en && !consume) begin
            level_d = level + ONE;
        end else if (consume && !wr_en) begin
            level_d = level - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            almost_full <= 1'b0;
            in_if.ack   <= 1'b0;
            out_if.data <= '0;
        end else if (flush) begin
            // Same clearing as reset, but the last presented word stays on out_if.data.
            state_q     <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            almost_full <= 1'b0;
            in_if.ack   <= 1'b0;
        end else begin
            state_q     <= state_d;
            level       <= level_d;
            almost_full <= (level_d >= AFULL_L);
            in_if.ack   <= wr_en;
            if (wr_en) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (rd_en) begin
                rd_ptr      <= rd_ptr + ONE;
                out_if.data <= mem[rd_ptr[DEPTH_LOG2-1:0]];
            end
        end
    end

    // Storage array, no reset. A read and write never hit the same address
    // at one edge: that would need a full RAM, which blocks writes.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= in_if.data;
        end
    end

    assign out_if.rdy    = (state_q == PRESENT);
    assign out_state_dbg = (state_q == PRESENT);
endmodule
